spart_rx_fifo: RTL and testbench
================================

# spart_rx_fifo

Parametrised SPART receive path: oversampled asynchronous serial deserialiser with majority-vote sampling, start-bit validation, framing/overrun detection, optional parity, and a show-ahead receive FIFO. Sits between the board RxD pin (via the baud generator's oversample `enable` tick) and the processor I/O bus, replacing the single-byte receiver.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..9, LSB first.
- `OVERSAMPLE`, 16: `enable` ticks per bit, even, 8..32.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of 2, 2..64.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial line, idle high, asynchronous.
- `enable` in 1: oversample tick, one `clk` wide, OVERSAMPLE per bit time.
- `iorw` in 1: 1 = processor read.
- `ioaddr` in 2: 2'b00 data, 2'b01 status.
- `rd_data` out DATA_BITS: FIFO head word (show-ahead).
- `rda` out 1: FIFO not empty.
- `status` out 8: {3'b0, level_full, parity_err, frame_err, overrun, rda}.

## Operation
- `rxd` passes a 2-FF synchroniser reset to 1; all logic uses the synchronised value.
- Sample counter `sc` (log2(OVERSAMPLE) bits) advances only on `enable`; vote taken from samples OVERSAMPLE/2-1, /2, /2+1 (2-of-3 majority).
- FSM: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: `enable` && line 0 → START, `sc`=1.
  - START: at vote point majority 1 → IDLE (glitch rejected, nothing recorded); majority 0 → DATA at end of bit (`sc` wraps to 0).
  - DATA: shift voted bit into shift register MSB-first-in (LSB first on line); after DATA_BITS bits → PARITY (macro defined) else STOP.
  - PARITY: voted bit compared to even parity of payload.
  - STOP: each of STOP_BITS votes must be 1. At final stop vote point (mid-bit, not end) frame completes: push payload, → IDLE if stop good, → WAIT_HIGH if any stop bit voted 0.
  - WAIT_HIGH: stays until a vote-free `enable` sample sees line 1, then IDLE (prevents break retriggering).
- Errors are sticky status bits: `frame_err` (bad stop), `parity_err`, `overrun`. Frames with frame/parity error are still pushed.
- Push when FIFO full → word dropped, `overrun` set. Push and pop same cycle while full → both happen, no overrun.
- Pop: `iorw`=1 && `ioaddr`=00 && `rda`; pop while empty ignored.
- Status read: `iorw`=1 && `ioaddr`=01 clears `frame_err`, `parity_err`, `overrun` after the cycle; an error event in the same cycle wins (flag stays set).
- FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ, lower bits equal.
- `level_full` = FIFO full.

## Timing
- Reset: FSM IDLE, counters 0, FIFO empty, storage 0 → `rd_data`=0, `rda`=0, `status`=0.
- `rxd` to FSM: 2 `clk` synchroniser latency.
- Push registered on the `clk` edge following the final stop vote `enable`; `rda` rises the same edge; `rd_data` valid then.
- `rd_data`/`rda` update on the edge after a pop; back-to-back pops on consecutive cycles allowed.
- Reset asserted mid-frame: partial frame discarded, FIFO emptied.
- `enable` held low: all receive state frozen; bus side still operates.

## Configuration
- `SPART_RX_PARITY_EN` defined: PARITY state present, even parity checked, `parity_err` live.
- Undefined: PARITY state removed, STOP follows DATA, `status[3]` tied 0.

## Structure
- Shared package `spart_pkg`: FSM state enum, `ADDR_DATA`/`ADDR_STATUS` constants, status bit index constants (shared with transmit block).
- One sub-module: `spart_fifo` (parametrised DATA_BITS × FIFO_DEPTH, show-ahead, push/pop/full/empty).

## Test plan
- 0x55 at OVERSAMPLE=16, one stop → `rda`=1, `rd_data`=8'h55, `status`=8'h01; pop → `rda`=0.
- 3-tick low glitch on idle line → no push, FSM back in IDLE, `status`=0.
- Frame 0xA3 with stop bit 0 → 0xA3 pushed, `frame_err`=1, no new frame accepted until line high; status read clears it.
- FIFO_DEPTH=4, send 5 frames 0x01..0x05 without popping → pops return 0x01..0x04, `overrun`=1; simultaneous pop+push at full → no overrun.
- Macro defined, 0x07 sent with parity bit 0 → `parity_err`=1, `rd_data`=8'h07; parity 1 → no error.
- `rst_n` low mid-data bit 4 → `rda`=0, `status`=0; next clean frame 0x3C received correctly.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, bus addresses, status bit positions.
// Used by both the receive and transmit blocks so the processor sees one register map.
package spart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

    localparam int STAT_RDA        = 0;
    localparam int STAT_OVERRUN    = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_PARITY_ERR = 3;
    localparam int STAT_LEVEL_FULL = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// Show-ahead FIFO, WIDTH x DEPTH (DEPTH a power of 2); head word visible combinationally.
// Latency: push visible at o_head_dat on the next edge. Push while full is dropped unless a pop
// happens in the same cycle; pop while empty is ignored.
module spart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled 2-of-3 vote deserialiser feeding a show-ahead FIFO; optional even parity via SPART_RX_PARITY_EN.
// Latency: word pushed on the edge after the final stop-bit vote tick; rxd sees 2 clk of sync.
// Backpressure: none on the line; push into a full FIFO drops the word and sets overrun.
module spart_rx_fifo
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 enable,
    input  logic                 iorw,
    input  logic [1:0]           ioaddr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rda,
    output logic [7:0]           status
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);

    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
    localparam logic [SC_W-1:0] SC_V0   = SC_W'(OVERSAMPLE/2 - 1);
    localparam logic [SC_W-1:0] SC_V1   = SC_W'(OVERSAMPLE/2);
    localparam logic [SC_W-1:0] SC_VOTE = SC_W'(OVERSAMPLE/2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_BITS);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    rx_state_e            r_state,    w_state_nxt;
    logic [SC_W-1:0]      r_sc,       w_sc_nxt;
    logic [BC_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_s0,       w_s0_nxt;
    logic                 r_s1,       w_s1_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_stop_bad, w_stop_bad_nxt;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic            w_vote;
    logic            w_vote_pt;
    logic            w_bit_end;
    logic [SC_W-1:0] w_sc_adv;
    logic            w_stop_bad_now;
    logic            w_push;
    logic            w_push_bad_stop;
    logic            w_pop;
    logic            w_stat_rd;
    logic            w_full;
    logic            w_empty;
    logic            w_parity_flag;

`ifdef SPART_RX_PARITY_EN
    logic r_par_bad, w_par_bad_nxt;
    logic r_parity_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_vote         = maj3(r_s0, r_s1, r_rxd_sync);
    assign w_vote_pt      = (r_sc == SC_VOTE);
    assign w_bit_end      = (r_sc == SC_LAST);
    assign w_sc_adv       = w_bit_end ? '0 : r_sc + SC_ONE;
    assign w_stop_bad_now = r_stop_bad | ~w_vote;

    always_comb begin
        w_state_nxt     = r_state;
        w_sc_nxt        = r_sc;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_s0_nxt        = r_s0;
        w_s1_nxt        = r_s1;
        w_stop_cnt_nxt  = r_stop_cnt;
        w_stop_bad_nxt  = r_stop_bad;
        w_push          = 1'b0;
        w_push_bad_stop = 1'b0;
`ifdef SPART_RX_PARITY_EN
        w_par_bad_nxt   = r_par_bad;
`endif
        if (enable) begin
            if (r_sc == SC_V0) w_s0_nxt = r_rxd_sync;
            if (r_sc == SC_V1) w_s1_nxt = r_rxd_sync;
            case (r_state)
                ST_IDLE: begin
                    // The detecting tick counts as sample 0 of the start bit.
                    if (!r_rxd_sync) begin
                        w_state_nxt    = ST_START;
                        w_sc_nxt       = SC_ONE;
                        w_bit_cnt_nxt  = '0;
                        w_stop_cnt_nxt = 1'b0;
                        w_stop_bad_nxt = 1'b0;
`ifdef SPART_RX_PARITY_EN
                        w_par_bad_nxt  = 1'b0;
`endif
                    end
                end
                ST_START: begin
                    w_sc_nxt = w_sc_adv;
                    if (w_vote_pt && w_vote) begin
                        w_state_nxt = ST_IDLE;
                        w_sc_nxt    = '0;
                    end else if (w_bit_end) begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_sc_nxt = w_sc_adv;
                    if (w_vote_pt) begin
                        w_shift_nxt   = {w_vote, r_shift[DATA_BITS-1:1]};
                        w_bit_cnt_nxt = r_bit_cnt + BC_ONE;
                    end
                    if (w_bit_end && (r_bit_cnt == BC_FULL)) begin
`ifdef SPART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
`ifdef SPART_RX_PARITY_EN
                ST_PARITY: begin
                    w_sc_nxt = w_sc_adv;
                    if (w_vote_pt) w_par_bad_nxt = (w_vote != (^r_shift));
                    if (w_bit_end) w_state_nxt = ST_STOP;
                end
`endif
                ST_STOP: begin
                    w_sc_nxt = w_sc_adv;
                    if (w_vote_pt) begin
                        w_stop_bad_nxt = w_stop_bad_now;
                        // Frame completes mid-bit so a following start edge is never missed.
                        if (r_stop_cnt == STOP_LAST) begin
                            w_push          = 1'b1;
                            w_push_bad_stop = w_stop_bad_now;
                            w_state_nxt     = w_stop_bad_now ? ST_WAIT_HIGH : ST_IDLE;
                            w_sc_nxt        = '0;
                        end
                    end else if (w_bit_end) begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (r_rxd_sync) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sc       <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sc       <= w_sc_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_s0       <= w_s0_nxt;
            r_s1       <= w_s1_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_stop_bad <= w_stop_bad_nxt;
        end
    end

    assign w_pop     = iorw && (ioaddr == ADDR_DATA) && rda;
    assign w_stat_rd = iorw && (ioaddr == ADDR_STATUS);

    spart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (r_shift),
        .i_pop      (w_pop),
        .o_head_dat (rd_data),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    assign rda = ~w_empty;

    // Sticky flags: an event in the same cycle as a status read keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_push_bad_stop | (r_frame_err & ~w_stat_rd);
            r_overrun   <= (w_push & w_full & ~w_pop) | (r_overrun & ~w_stat_rd);
        end
    end

`ifdef SPART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= (w_push & r_par_bad) | (r_parity_err & ~w_stat_rd);
        end
    end
    assign w_parity_flag = r_parity_err;
`else
    assign w_parity_flag = 1'b0;
`endif

    always_comb begin
        status                  = 8'h00;
        status[STAT_RDA]        = rda;
        status[STAT_OVERRUN]    = r_overrun;
        status[STAT_FRAME_ERR]  = r_frame_err;
        status[STAT_PARITY_ERR] = w_parity_flag;
        status[STAT_LEVEL_FULL] = w_full;
    end

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: serial frames driven tick by tick, results checked against a queue model.
module tb_spart_rx_fifo;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int SB = 1;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          enable = 1'b0;
    logic          iorw = 1'b0;
    logic [1:0]    ioaddr = 2'b11;
    logic [DB-1:0] rd_data;
    logic          rda;
    logic [7:0]    status;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DB-1:0] mq[$];
    bit m_ferr, m_perr, m_ovr;

    spart_rx_fifo #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .enable  (enable),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .rd_data (rd_data),
        .rda     (rda),
        .status  (status)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (mq.size() != 0);
        s[1] = m_ovr;
        s[2] = m_ferr;
        s[3] = m_perr;
        s[4] = (mq.size() == FD);
        return s;
    endfunction

    task automatic model_frame(input logic [DB-1:0] d, input bit stop_ok, input bit par_flip);
        if (mq.size() == FD) m_ovr = 1'b1;
        else mq.push_back(d);
        if (!stop_ok) m_ferr = 1'b1;
`ifdef SPART_RX_PARITY_EN
        if (par_flip) m_perr = 1'b1;
`else
        if (par_flip) m_perr = 1'b0;
`endif
    endtask

    task automatic tick(input bit with_pop);
        @(negedge clk);
        enable = 1'b1;
        if (with_pop) begin
            iorw = 1'b1;
            ioaddr = 2'b00;
        end
        @(negedge clk);
        enable = 1'b0;
        iorw = 1'b0;
        ioaddr = 2'b11;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_bits(input logic b, input int nbits);
        rxd = b;
        repeat (nbits * OS) tick(1'b0);
    endtask

    // pop_at_push: pop lands on the same edge as the frame's push (line lags FSM by one tick).
    task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input bit par_flip,
                              input int extra_low, input bit pop_at_push);
        send_bits(1'b0, 1);
        for (int i = 0; i < DB; i++) send_bits(d[i], 1);
`ifdef SPART_RX_PARITY_EN
        send_bits((^d) ^ par_flip, 1);
`endif
        for (int s = 0; s < SB; s++) begin
            rxd = stop_ok;
            for (int t = 0; t < OS; t++) tick(pop_at_push && (s == SB - 1) && (t == OS/2 + 2));
        end
        if (!stop_ok && extra_low > 0) send_bits(1'b0, extra_low);
        send_bits(1'b1, 1);
    endtask

    task automatic bus_pop();
        @(negedge clk);
        iorw = 1'b1;
        ioaddr = 2'b00;
        @(negedge clk);
        iorw = 1'b0;
        ioaddr = 2'b11;
    endtask

    task automatic bus_status_rd();
        @(negedge clk);
        iorw = 1'b1;
        ioaddr = 2'b01;
        @(negedge clk);
        iorw = 1'b0;
        ioaddr = 2'b11;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_ferr = 0; m_perr = 0; m_ovr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rxd = 1'b1;
        do_reset();
        n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got=%b want=0", rda); end
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status got=%h want=00", status); end
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    endtask

    task automatic test_single_frame();
        send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h55, 1'b1, 1'b0);
        n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL single_rda got=%b want=1", rda); end
        n_tests++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL single_data got=%h want=55", rd_data); end
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL single_status got=%h want=01", status); end
        bus_pop();
        void'(mq.pop_front());
        n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL single_pop_rda got=%b want=0", rda); end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (3) tick(1'b0);
        send_bits(1'b1, 2);
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL glitch_status got=%h want=00", status); end
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0);
        n_tests++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_data got=%h want=5a", rd_data); end
        n_tests++; if (status !== exp_status()) begin n_fail++; $display("FAIL glitch_next_status got=%h want=%h", status, exp_status()); end
        bus_pop();
        void'(mq.pop_front());
    endtask

    task automatic test_frame_err();
        send_frame(8'hA3, 1'b0, 1'b0, DB + 3, 1'b0);
        model_frame(8'hA3, 1'b0, 1'b0);
        n_tests++; if (status !== 8'h05) begin n_fail++; $display("FAIL ferr_status got=%h want=05", status); end
        n_tests++; if (rd_data !== 8'hA3) begin n_fail++; $display("FAIL ferr_data got=%h want=a3", rd_data); end
        bus_status_rd();
        m_ferr = 0;
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL ferr_clear got=%h want=01", status); end
        bus_pop();
        void'(mq.pop_front());
        n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL ferr_single_entry rda got=%b want=0", rda); end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            send_frame(DB'(i), 1'b1, 1'b0, 0, 1'b0);
            model_frame(DB'(i), 1'b1, 1'b0);
        end
        n_tests++; if (status !== 8'h13) begin n_fail++; $display("FAIL ovr_status got=%h want=13", status); end
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (rd_data !== DB'(i)) begin n_fail++; $display("FAIL ovr_pop%0d got=%h want=%h", i, rd_data, DB'(i)); end
            bus_pop();
            void'(mq.pop_front());
        end
        n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL ovr_drained rda got=%b want=0", rda); end
        bus_status_rd();
        m_ovr = 0;
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL ovr_clear got=%h want=00", status); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < FD; i++) begin
            send_frame(DB'(8'h11 + i), 1'b1, 1'b0, 0, 1'b0);
            model_frame(DB'(8'h11 + i), 1'b1, 1'b0);
        end
        send_frame(8'h15, 1'b1, 1'b0, 0, 1'b1);
        void'(mq.pop_front());
        model_frame(8'h15, 1'b1, 1'b0);
        n_tests++; if (status !== 8'h11) begin n_fail++; $display("FAIL full_pushpop_status got=%h want=11", status); end
        while (mq.size() != 0) begin
            n_tests++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL full_pushpop_data got=%h want=%h", rd_data, mq[0]); end
            bus_pop();
            void'(mq.pop_front());
        end
    endtask

`ifdef SPART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
        model_frame(8'h07, 1'b1, 1'b1);
        n_tests++; if (status !== 8'h09) begin n_fail++; $display("FAIL parity_bad_status got=%h want=09", status); end
        n_tests++; if (rd_data !== 8'h07) begin n_fail++; $display("FAIL parity_bad_data got=%h want=07", rd_data); end
        bus_status_rd();
        m_perr = 0;
        bus_pop();
        void'(mq.pop_front());
        send_frame(8'h07, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0);
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL parity_good_status got=%h want=01", status); end
        bus_pop();
        void'(mq.pop_front());
    endtask
`endif

    task automatic test_reset_mid();
        send_frame(8'h99, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h99, 1'b1, 1'b0);
        send_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bits(1'b1, 1);
        rxd = 1'b0;
        repeat (5) tick(1'b0);
        do_reset();
        n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL rstmid_rda got=%b want=0", rda); end
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL rstmid_status got=%h want=00", status); end
        send_bits(1'b1, 2);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        n_tests++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_data got=%h want=3c", rd_data); end
        n_tests++; if (status !== 8'h01) begin n_fail++; $display("FAIL rstmid_next_status got=%h want=01", status); end
        bus_pop();
        void'(mq.pop_front());
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        bit stop_ok, pf;
        for (int n = 0; n < 18; n++) begin
            d = DB'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
`ifdef SPART_RX_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
`else
            pf = 1'b0;
`endif
            send_frame(d, stop_ok, pf, 0, 1'b0);
            model_frame(d, stop_ok, pf);
            n_tests++; if (status !== exp_status()) begin n_fail++; $display("FAIL rand%0d_status got=%h want=%h", n, status, exp_status()); end
            repeat ($urandom_range(0, 2)) begin
                if (mq.size() != 0) begin
                    n_tests++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL rand%0d_data got=%h want=%h", n, rd_data, mq[0]); end
                    void'(mq.pop_front());
                end
                bus_pop();
            end
            n_tests++; if (rda !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand%0d_rda got=%b want=%b", n, rda, mq.size() != 0); end
            if ($urandom_range(0, 3) == 0) begin
                bus_status_rd();
                m_ferr = 0; m_perr = 0; m_ovr = 0;
                n_tests++; if (status !== exp_status()) begin n_fail++; $display("FAIL rand%0d_clear got=%h want=%h", n, status, exp_status()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_pop_full();
`ifdef SPART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
